mini_alu_core: RTL and testbench

MINI_ALU_CORE -- requirements
Module: mini_alu_core

---
 rtl/mini_alu_core.sv | 189 ++++++++++++++++++
 tb/tb_mini_alu_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_core.sv
// mini_alu_core: 2-stage fetch/execute core, 256 x DATA_W register file, registered LED output.
// Optional MINI_ALU_MUL_EN builds the iterative radix-2 Booth SMUL unit; otherwise SMUL is a NOP.
module mini_alu_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LED_W  = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    output logic [7:0]       oIP,
    input  logic [27:0]      iInstruction,
    output logic [LED_W-1:0] oLed,
    output logic             oBusy,
    output logic             oHalt
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_STO  = 4'd3,
        OP_BLE  = 4'd4,
        OP_JMP  = 4'd5,
        OP_LED  = 4'd6,
        OP_SMUL = 4'd7,
        OP_HLT  = 4'd8
    } opcode_e;

    logic [7:0]        ip_q, ip_d;
    logic [27:0]       ir_q, ir_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              halt_q, halt_d;
    logic [DATA_W-1:0] rf [256];

    logic [3:0]        op;
    logic [7:0]        dest, src1, src0;
    logic [DATA_W-1:0] rs1, rs0;

    logic                we0, we1, take;
    logic [7:0]          wa0, wa1;
    logic [DATA_W-1:0]   wd0, wd1;
    logic                mul_stall, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign op   = ir_q[27:24];
    assign dest = ir_q[23:16];
    assign src1 = ir_q[15:8];
    assign src0 = ir_q[7:0];
    assign rs1  = rf[src1];
    assign rs0  = rf[src0];

`ifdef MINI_ALU_MUL_EN
    typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;

    mul_state_e        state_q, state_d;
    logic [DATA_W:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [DATA_W-1:0] mq_q, mq_d;
    logic              q1_q, q1_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              is_smul, mul_capture, mul_step;
    logic [DATA_W:0]   booth_sum;

    assign is_smul = (op == OP_SMUL);
    assign oBusy   = is_smul;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= MUL_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mq_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin : mul_next_state
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (is_smul) state_d = MUL_RUN;
            MUL_RUN:  if (cnt_q == 6'(DATA_W - 1)) state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Accumulator is DATA_W+1 bits so subtracting the most negative multiplicand cannot overflow.
    always_comb begin : mul_outputs
        mul_capture = (state_q == MUL_IDLE) && is_smul;
        mul_step    = (state_q == MUL_RUN);
        mul_done    = mul_step && (cnt_q == 6'(DATA_W - 1));
        mul_stall   = is_smul && !mul_done;
        booth_sum   = acc_q;
        case ({mq_q[0], q1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        if (mul_capture) begin
            acc_d   = '0;
            mcand_d = {rs1[DATA_W-1], rs1};
            mq_d    = rs0;
            q1_d    = 1'b0;
            cnt_d   = '0;
        end else if (mul_step) begin
            acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
            mq_d  = {booth_sum[0], mq_q[DATA_W-1:1]};
            q1_d  = mq_q[0];
            cnt_d = cnt_q + 6'd1;
        end
        mul_prod = {acc_d[DATA_W-1:0], mq_d};
    end
`else
    assign oBusy     = 1'b0;
    assign mul_stall = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`endif

    always_comb begin : execute
        ip_d   = ip_q;
        ir_d   = ir_q;
        led_d  = led_q;
        halt_d = halt_q;
        we0    = 1'b0;
        wa0    = dest;
        wd0    = '0;
        we1    = 1'b0;
        wa1    = dest + 8'd1;
        wd1    = '0;
        take   = 1'b0;
        case (op)
            OP_ADD: begin we0 = 1'b1; wd0 = rs1 + rs0; end
            OP_SUB: begin we0 = 1'b1; wd0 = rs1 - rs0; end
            OP_STO: begin we0 = 1'b1; wd0 = DATA_W'({src1, src0}); end
            OP_BLE: take = (rs1 <= rs0);
            OP_JMP: take = 1'b1;
            OP_LED: led_d = rs1[LED_W-1:0];
            OP_HLT: halt_d = 1'b1;
            default: ;
        endcase
        if (mul_done) begin
            we0 = 1'b1;
            wd0 = mul_prod[DATA_W-1:0];
            we1 = 1'b1;
            wd1 = mul_prod[2*DATA_W-1:DATA_W];
        end
        // A taken branch squashes the already-fetched word; HLT and SMUL hold fetch.
        if (take) begin
            ip_d = dest;
            ir_d = '0;
        end else if ((op != OP_HLT) && !mul_stall) begin
            ip_d = ip_q + 8'd1;
            ir_d = iInstruction;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ip_q   <= '0;
            ir_q   <= '0;
            led_q  <= '0;
            halt_q <= 1'b0;
        end else begin
            ip_q   <= ip_d;
            ir_q   <= ir_d;
            led_q  <= led_d;
            halt_q <= halt_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (we0) rf[wa0] <= wd0;
        if (we1) rf[wa1] <= wd1;
    end

    assign oIP   = ip_q;
    assign oLed  = led_q;
    assign oHalt = halt_q;
endmodule

// File: tb/tb_mini_alu_core.sv
// Scoreboard bench for mini_alu_core: a 16-bit core (full-width LED) and an 8-bit core.
// Expectations adapt to whether MINI_ALU_MUL_EN is defined for the build.
module tb_mini_alu_core;
`ifdef MINI_ALU_MUL_EN
    localparam logic [15:0] EXP_R4   = 16'hFFEB;
    localparam logic [15:0] EXP_R5   = 16'hFFFF;
    localparam logic [15:0] EXP_R1   = 16'hFFEB;
    localparam logic [15:0] EXP_R2   = 16'hFFFF;
    localparam int          EXP_RUNS = 2;
    localparam int          EXP_BUSY = 8;
`else
    localparam logic [15:0] EXP_R4   = 16'h1234;
    localparam logic [15:0] EXP_R5   = 16'h5678;
    localparam logic [15:0] EXP_R1   = 16'hFFFD;
    localparam logic [15:0] EXP_R2   = 16'h0007;
    localparam int          EXP_RUNS = 0;
    localparam int          EXP_BUSY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst16_n, rst8_n;
    logic [7:0]  ip16, ip8;
    logic [27:0] ins16, ins8;
    logic [15:0] led16;
    logic [7:0]  led8;
    logic        busy16, busy8, halt16, halt8;
    logic [27:0] rom16 [256];
    logic [27:0] rom8  [256];

    always #5 clk = ~clk;
    assign ins16 = rom16[ip16];
    assign ins8  = rom8[ip8];

    mini_alu_core #(.DATA_W(16), .LED_W(16)) u_dut16 (
        .Clock(clk), .Reset_n(rst16_n), .oIP(ip16), .iInstruction(ins16),
        .oLed(led16), .oBusy(busy16), .oHalt(halt16));

    mini_alu_core #(.DATA_W(8), .LED_W(8)) u_dut8 (
        .Clock(clk), .Reset_n(rst8_n), .oIP(ip8), .iInstruction(ins8),
        .oLed(led8), .oBusy(busy8), .oHalt(halt8));

    int          total = 0;
    int          bad   = 0;
    logic [15:0] q16 [$];
    logic [7:0]  q8  [$];
    logic [15:0] last16;
    logic [7:0]  last8;
    int          busy_runs [$];
    int          busy_run = 0;
    int          ip_moves = 0;
    logic [7:0]  busy_ip;

    function automatic logic [27:0] ins(input int op, input int d, input int s1, input int s0);
        return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // LED monitors: every change of oLed is one DUT output, matched against the queue.
    always @(negedge clk) begin
        if (!rst16_n) last16 = led16;
        else if (led16 !== last16) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL led16_unexpected: got=0x%0h want=none", led16);
            end else chk("led16", {16'h0, led16}, {16'h0, q16.pop_front()});
            last16 = led16;
        end
    end

    always @(negedge clk) begin
        if (!rst8_n) last8 = led8;
        else if (led8 !== last8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL led8_unexpected: got=0x%0h want=none", led8);
            end else chk("led8", {24'h0, led8}, {24'h0, q8.pop_front()});
            last8 = led8;
        end
    end

    always @(negedge clk) begin
        if (rst16_n && busy16) begin
            if (busy_run == 0) busy_ip = ip16;
            else if (ip16 !== busy_ip) ip_moves++;
            busy_run++;
        end else if (busy_run > 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    task automatic clear16();
        for (int i = 0; i < 256; i++) rom16[i] = '0;
    endtask

    initial begin
        int c;
        int chg_ip, chg_led;
        logic [7:0] ip_ref, led_ref;

        rst16_n = 1'b0;
        rst8_n  = 1'b0;
        clear16();
        for (int i = 0; i < 256; i++) rom8[i] = '0;

        // Program A, 16-bit core
        rom16[8'h00] = ins(3, 1, 0, 5);
        rom16[8'h01] = ins(3, 2, 0, 3);
        rom16[8'h02] = ins(1, 3, 1, 2);
        rom16[8'h03] = ins(6, 0, 3, 0);           q16.push_back(16'h0008);
        rom16[8'h04] = ins(3, 10, 0, 0);
        rom16[8'h05] = ins(3, 11, 0, 1);
        rom16[8'h06] = ins(2, 12, 10, 11);
        rom16[8'h07] = ins(6, 0, 12, 0);          q16.push_back(16'hFFFF);
        rom16[8'h08] = ins(3, 4, 8'h12, 8'h34);
        rom16[8'h09] = ins(3, 5, 8'h56, 8'h78);
        rom16[8'h0A] = ins(3, 1, 8'hFF, 8'hFD);
        rom16[8'h0B] = ins(3, 2, 0, 7);
        rom16[8'h0C] = ins(7, 4, 1, 2);
        rom16[8'h0D] = ins(6, 0, 4, 0);           q16.push_back(EXP_R4);
        rom16[8'h0E] = ins(6, 0, 5, 0);           q16.push_back(EXP_R5);
        rom16[8'h0F] = ins(7, 1, 1, 2);
        rom16[8'h10] = ins(6, 0, 1, 0);           q16.push_back(EXP_R1);
        rom16[8'h11] = ins(6, 0, 2, 0);           q16.push_back(EXP_R2);
        rom16[8'h12] = ins(3, 6, 0, 8'h55);
        rom16[8'h13] = ins(5, 8'h20, 0, 0);
        rom16[8'h14] = ins(3, 6, 0, 8'hAA);
        rom16[8'h15] = ins(6, 0, 6, 0);
        rom16[8'h20] = ins(6, 0, 6, 0);           q16.push_back(16'h0055);
        rom16[8'h21] = ins(3, 7, 0, 3);
        rom16[8'h22] = ins(3, 8, 0, 5);
        rom16[8'h23] = ins(3, 9, 0, 6);
        rom16[8'h24] = ins(4, 8'h30, 7, 8);
        rom16[8'h25] = ins(6, 0, 8, 0);
        rom16[8'h30] = ins(6, 0, 7, 0);           q16.push_back(16'h0003);
        rom16[8'h31] = ins(4, 8'h40, 9, 8);
        rom16[8'h32] = ins(6, 0, 9, 0);           q16.push_back(16'h0006);
        rom16[8'h33] = ins(3, 13, 0, 8'h77);
        rom16[8'h34] = ins(6, 0, 13, 0);          q16.push_back(16'h0077);
        rom16[8'h35] = ins(3, 14, 0, 9);
        rom16[8'h36] = ins(3, 15, 0, 1);
        rom16[8'h37] = ins(8, 0, 0, 0);
        rom16[8'h40] = ins(6, 0, 8, 0);
        rom16[8'h41] = ins(8, 0, 0, 0);

        // 8-bit core: SUB wrap, STO truncation, HLT at 0x07
        rom8[0] = ins(3, 1, 0, 0);
        rom8[1] = ins(3, 2, 0, 1);
        rom8[2] = ins(2, 3, 1, 2);
        rom8[3] = ins(6, 0, 3, 0);                q8.push_back(8'hFF);
        rom8[4] = ins(3, 4, 8'h01, 8'hAB);
        rom8[5] = ins(6, 0, 4, 0);                q8.push_back(8'hAB);
        rom8[7] = ins(8, 0, 0, 0);
        rom8[8] = ins(3, 5, 0, 8'h11);
        rom8[9] = ins(6, 0, 5, 0);

        #2;
        chk("rst_ip16",   {24'h0, ip16},   32'h0);
        chk("rst_led16",  {16'h0, led16},  32'h0);
        chk("rst_busy16", {31'h0, busy16}, 32'h0);
        chk("rst_halt16", {31'h0, halt16}, 32'h0);
        chk("rst_ip8",    {24'h0, ip8},    32'h0);
        chk("rst_busy8",  {31'h0, busy8},  32'h0);

        @(posedge clk); #1;
        rst16_n = 1'b1;
        rst8_n  = 1'b1;
        @(posedge clk); #1;
        chk("first_fetch_ip16", {24'h0, ip16}, 32'h1);

        c = 0;
        while (c < 600 && !(halt16 && halt8)) begin
            @(posedge clk); #1;
            c++;
        end
        chk("halt16_reached", {31'h0, halt16}, 32'h1);
        chk("halt8_reached",  {31'h0, halt8},  32'h1);

        ip_ref = ip8; led_ref = led8; chg_ip = 0; chg_led = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (ip8 !== ip_ref) chg_ip++;
            if (led8 !== led_ref) chg_led++;
        end
        chk("halt8_ip_changes",  chg_ip,  0);
        chk("halt8_led_changes", chg_led, 0);
        chk("halt8_led_value", {24'h0, led8}, 32'hAB);
        chk("halt8_still_set", {31'h0, halt8}, 32'h1);
        chk("progA_led16_pending", q16.size(), 0);
        chk("led8_pending", q8.size(), 0);
        chk("smul_busy_runs", busy_runs.size(), EXP_RUNS);
        foreach (busy_runs[i]) chk("smul_busy_len", busy_runs[i], 17);
        chk("smul_ip_moves", ip_moves, 0);

        // Program B: SMUL aborted by reset in its 8th cycle
        rst16_n = 1'b0;
        #1;
        chk("rst2_halt16", {31'h0, halt16}, 32'h0);
        clear16();
        rom16[0] = ins(7, 4, 7, 8);
        rom16[1] = ins(8, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst16_n = 1'b1;
        @(posedge clk); #1;
        chk("progB_first_fetch", {24'h0, ip16}, 32'h1);
        c = busy16 ? 1 : 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (busy16) c++;
        end
        chk("progB_busy_cycles", c, EXP_BUSY);
        rst16_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy16}, 32'h0);
        chk("abort_ip",   {24'h0, ip16},   32'h0);

        // Program C: dest regs intact, wrap 0xFF -> 0x00 takes the BLE on the second visit
        clear16();
        rom16[8'h00] = ins(4, 8'h10, 14, 15);
        rom16[8'h01] = ins(6, 0, 4, 0);           q16.push_back(EXP_R4);
        rom16[8'h02] = ins(6, 0, 5, 0);           q16.push_back(EXP_R5);
        rom16[8'h03] = ins(3, 14, 0, 0);
        rom16[8'h04] = ins(5, 8'hFF, 0, 0);
        rom16[8'hFF] = ins(6, 0, 13, 0);          q16.push_back(16'h0077);
        rom16[8'h10] = ins(6, 0, 14, 0);          q16.push_back(16'h0000);
        rom16[8'h11] = ins(8, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst16_n = 1'b1;
        @(posedge clk); #1;
        chk("progC_first_fetch", {24'h0, ip16}, 32'h1);
        c = 0;
        while (c < 300 && !halt16) begin
            @(posedge clk); #1;
            c++;
        end
        chk("progC_halt", {31'h0, halt16}, 32'h1);
        @(posedge clk); #1;
        chk("progC_led16_pending", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
